id_ex_hazard_reg: RTL
=====================

// Module: id_ex_hazard_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core with integrated load-use hazard detection.
//  Captures decoded control and operands from ID, presents them to EX, and supplies the
//  forwarding unit's id_ex_RsAddr/id_ex_RtAddr inputs.
//  Forwarding cannot bypass from a load in MEM, so this block stalls IF/ID for one cycle
//  and inserts a bubble whenever an ID instruction depends on a load in EX.
// PARAMETERS
//  DATA_W   32  register-file / operand width
//  CNT_W    32  width of the saturating stall counter
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  hold           in   1       global freeze (memory wait); ID/EX and counter keep their values
//  flush          in   1       squash the ID instruction (taken branch/jump resolved in EX)
//  id_RsAddr      in   5       ID source register rs
//  id_RtAddr      in   5       ID source register rt
//  id_RdAddr      in   5       ID destination rd
//  id_UsesRs      in   1       ID instruction reads rs
//  id_UsesRt      in   1       ID instruction reads rt
//  id_RsData      in   DATA_W  register-file rs value
//  id_RtData      in   DATA_W  register-file rt value
//  id_Imm32       in   DATA_W  sign/zero-extended immediate
//  id_ALUCtrl     in   4       ALU operation
//  id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite  in 1  decoded controls
//  ex_*           out  (as ID) registered copies of every id_* input above (ex_RsAddr feeds id_ex_RsAddr)
//  ex_RegWriteAddr out 5       ex_RegDst ? ex_RdAddr : ex_RtAddr (combinational from registers)
//  stall          out  1       hold PC and IF/ID this cycle (combinational)
//  stall_count    out  CNT_W   number of load-use bubbles inserted, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): all ex_* registers 0 (bubble: RegWrite/MemRead/MemWrite=0), stall_count=0.
//  Hazard (combinational): hz = ex_MemRead & ex_RegWriteAddr!=0 &
//    ((id_UsesRs & id_RsAddr==ex_RegWriteAddr) | (id_UsesRt & id_RtAddr==ex_RegWriteAddr)).
//  stall = hz & ~flush & ~hold.  While hold=1, stall=0; hold alone freezes the pipe.
//  Per rising edge, priority high->low:
//    1. hold:   all registers keep their values.
//    2. flush:  ID/EX loads a bubble (all ex_* = 0); hz is ignored and stall_count is unchanged.
//    3. hz:     ID/EX loads a bubble; stall_count += 1 unless all ones.
//    4. else:   ID/EX loads every id_* input. Latency ID->EX is 1 cycle.
//  A bubble never re-triggers hz, because ex_MemRead=0. Each load-use pair therefore costs
//    exactly 1 stall cycle. On the next cycle the load is in MEM and the dependant is still in ID.
//    The dependant then enters EX as the load reaches WB, and WB forwarding covers it.
//  A load that writes $0 never stalls.
//  Back-to-back loads with a chained dependence stall once per pair.
//  hold and flush together: hold wins; flush must be re-presented after hold drops.
//  stall_count saturates at 2^CNT_W-1 and never wraps.
//  Reset asserted mid-stall: outputs go to bubble immediately and stall drops.
// TESTING
//  1. Reset: rst_n=0 mid-cycle -> all ex_* = 0, stall=0, stall_count=0 without waiting for clk.
//  2. lw $2,0($1) then add $3,$2,$4 -> stall=1 for exactly 1 cycle, ex_RegWrite=0 next, stall_count=1,
//     add enters EX one cycle later with ex_RsAddr=2.
//  3. lw $0,0($1) then add $3,$0,$4 -> stall never asserts.
//  4. lw $5 in EX, ID reads rt=5 with id_UsesRt=0 -> no stall; with id_UsesRt=1 -> stall.
//  5. hz with flush=1 -> stall=0, bubble loaded, stall_count unchanged.
//     hold=1 for 3 cycles -> ex_* frozen for all 3.
//  6. CNT_W=2, trigger 5 load-use hazards -> stall_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination is read by the ID instruction forces a one-cycle bubble.
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic [4:0]        id_RsAddr,
    input  logic [4:0]        id_RtAddr,
    input  logic [4:0]        id_RdAddr,
    input  logic              id_UsesRs,
    input  logic              id_UsesRt,
    input  logic [DATA_W-1:0] id_RsData,
    input  logic [DATA_W-1:0] id_RtData,
    input  logic [DATA_W-1:0] id_Imm32,
    input  logic [3:0]        id_ALUCtrl,
    input  logic              id_RegDst,
    input  logic              id_ALUSrc,
    input  logic              id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    output logic [4:0]        ex_RsAddr,
    output logic [4:0]        ex_RtAddr,
    output logic [4:0]        ex_RdAddr,
    output logic              ex_UsesRs,
    output logic              ex_UsesRt,
    output logic [DATA_W-1:0] ex_RsData,
    output logic [DATA_W-1:0] ex_RtData,
    output logic [DATA_W-1:0] ex_Imm32,
    output logic [3:0]        ex_ALUCtrl,
    output logic              ex_RegDst,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic [4:0]        ex_RegWriteAddr,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [4:0]        rs_addr;
        logic [4:0]        rt_addr;
        logic [4:0]        rd_addr;
        logic              uses_rs;
        logic              uses_rt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm32;
        logic [3:0]        alu_ctrl;
        logic              reg_dst;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } idex_t;

    localparam idex_t      BUBBLE   = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    idex_t            id_bundle_s;
    idex_t            ex_r;
    logic [CNT_W-1:0] stall_count_r;
    logic [4:0]       ex_dest_s;
    logic             rs_match_s;
    logic             rt_match_s;
    logic             hz_s;

    // Gather the decoded ID-stage fields into one bundle for the register.
    always_comb begin
        id_bundle_s            = BUBBLE;
        id_bundle_s.rs_addr    = id_RsAddr;
        id_bundle_s.rt_addr    = id_RtAddr;
        id_bundle_s.rd_addr    = id_RdAddr;
        id_bundle_s.uses_rs    = id_UsesRs;
        id_bundle_s.uses_rt    = id_UsesRt;
        id_bundle_s.rs_data    = id_RsData;
        id_bundle_s.rt_data    = id_RtData;
        id_bundle_s.imm32      = id_Imm32;
        id_bundle_s.alu_ctrl   = id_ALUCtrl;
        id_bundle_s.reg_dst    = id_RegDst;
        id_bundle_s.alu_src    = id_ALUSrc;
        id_bundle_s.mem_to_reg = id_MemtoReg;
        id_bundle_s.reg_write  = id_RegWrite;
        id_bundle_s.mem_read   = id_MemRead;
        id_bundle_s.mem_write  = id_MemWrite;
    end

    // Load-use detection against the instruction currently held in EX.
    always_comb begin
        if (ex_r.reg_dst) begin
            ex_dest_s = ex_r.rd_addr;
        end else begin
            ex_dest_s = ex_r.rt_addr;
        end
        rs_match_s = id_UsesRs && (id_RsAddr == ex_dest_s);
        rt_match_s = id_UsesRt && (id_RtAddr == ex_dest_s);
        // Writes to $0 are discarded, so a load into $0 never creates a dependence.
        hz_s = ex_r.mem_read && (ex_dest_s != 5'd0) && (rs_match_s || rt_match_s);
    end

    // ID/EX register and bubble counter: hold > flush > hazard > advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r          <= BUBBLE;
            stall_count_r <= {CNT_W{1'b0}};
        end else if (hold) begin
            ex_r          <= ex_r;
            stall_count_r <= stall_count_r;
        end else if (flush) begin
            ex_r          <= BUBBLE;
            stall_count_r <= stall_count_r;
        end else if (hz_s) begin
            ex_r <= BUBBLE;
            if (stall_count_r != CNT_MAX) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end else begin
            ex_r          <= id_bundle_s;
            stall_count_r <= stall_count_r;
        end
    end

    assign stall           = hz_s && !flush && !hold;
    assign stall_count     = stall_count_r;
    assign ex_RegWriteAddr = ex_dest_s;

    assign ex_RsAddr   = ex_r.rs_addr;
    assign ex_RtAddr   = ex_r.rt_addr;
    assign ex_RdAddr   = ex_r.rd_addr;
    assign ex_UsesRs   = ex_r.uses_rs;
    assign ex_UsesRt   = ex_r.uses_rt;
    assign ex_RsData   = ex_r.rs_data;
    assign ex_RtData   = ex_r.rt_data;
    assign ex_Imm32    = ex_r.imm32;
    assign ex_ALUCtrl  = ex_r.alu_ctrl;
    assign ex_RegDst   = ex_r.reg_dst;
    assign ex_ALUSrc   = ex_r.alu_src;
    assign ex_MemtoReg = ex_r.mem_to_reg;
    assign ex_RegWrite = ex_r.reg_write;
    assign ex_MemRead  = ex_r.mem_read;
    assign ex_MemWrite = ex_r.mem_write;

endmodule
